// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads instruction memory and holds each word until it is acknowledged.
// Latency: at least 3 cycles per instruction (request accepted, response, acknowledge), then the next request.
// Backpressure: request and address hold while imem_ready is low; the held instruction is stable until instr_ack.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        instr_ack,
   input  logic [1:0]  sel_pc,
   input  logic [31:0] rs_data,
   output logic        fault,
   output logic [31:0] retired
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      HOLD  = 3'd3,
      ERROR = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] retired_q, retired_d;
   logic        fault_q, fault_d;
   logic [31:0] next_pc;
   logic [31:0] br_offset;

   // Outputs come straight from registers so nothing from the inputs leaks through combinationally.
   always_comb begin
      imem_req    = (state_q == REQ);
      imem_addr   = pc_q;
      instr_valid = (state_q == HOLD);
      instr       = instr_q;
      opcode      = instr_q[31:26];
      funct       = instr_q[5:0];
      pc          = pc_q;
      pc_plus4    = pc_q + 32'd4;
      fault       = fault_q;
      retired     = retired_q;
   end

   // Next-PC selection from the held instruction; only consumed on the acknowledge edge.
   always_comb begin
      br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
      next_pc   = pc_plus4;
      case (sel_pc)
         2'd0:    next_pc = pc_plus4;
         2'd1:    next_pc = pc_plus4 + br_offset;
         2'd2:    next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
         default: next_pc = rs_data;
      endcase
   end

   // Fetch sequencing; inputs are only honoured in the state that expects them.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      retired_d = retired_q;
      fault_d   = fault_q;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (imem_ready) state_d = WAIT;
         end
         WAIT: begin
            if (imem_rvalid) begin
               instr_d = imem_rdata;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (instr_ack) begin
               // A misaligned target still retires the instruction that produced it.
               retired_d = retired_q + 32'd1;
               if (next_pc[1:0] != 2'b00) begin
                  fault_d = 1'b1;
                  state_d = ERROR;
               end else begin
                  pc_d    = next_pc;
                  state_d = REQ;
               end
            end
         end
         ERROR: fault_d = 1'b1;
         default: state_d = IDLE;
      endcase
   end

   // State register; reset abandons any outstanding request.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         instr_q   <= 32'd0;
         retired_q <= 32'd0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         retired_q <= retired_d;
         fault_q   <= fault_d;
      end
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the MIPS core, directly upstream of `control_unit`. It owns the program counter and issues word reads to instruction memory over a request/response handshake. It holds each returned instruction, together with its decoded `opcode`/`funct` fields, until the downstream stage acknowledges it. On acknowledge it computes the next PC from the `sel_pc` select that `control_unit` produces.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clock` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `imem_req` out 1: read request valid.
- `imem_addr` out 32: read address, equal to `pc`.
- `imem_ready` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: read data valid.
- `imem_rdata` in 32: read data.
- `instr` out 32: held instruction.
- `instr_valid` out 1: `instr`, `opcode`, `funct`, `pc` and `pc_plus4` are valid for the downstream stage.
- `opcode` out 6: `instr[31:26]`.
- `funct` out 6: `instr[5:0]`.
- `pc` out 32: address of the held instruction.
- `pc_plus4` out 32: `pc + 4`, modulo 2^32.
- `instr_ack` in 1: downstream has consumed the instruction; advance the PC.
- `sel_pc` in 2: next-PC select, sampled only when ack is taken.
  - 0: `pc_plus4`.
  - 1: branch target.
  - 2: jump target.
  - 3: `rs_data` (JR).
- `rs_data` in 32: register value used for JR.
- `fault` out 1: sticky misaligned-target flag.
- `retired` out 32: count of acknowledged instructions; wraps.

## Operation
- The FSM has five states: IDLE, REQ, WAIT, HOLD, ERROR.
- Reset (asynchronous) forces:
  - state = IDLE, `pc` = `RESET_PC`, `instr` = 0, `retired` = 0, `fault` = 0.
  - Every output takes its reset value: `instr_valid` 0, `imem_req` 0, `imem_addr` `RESET_PC`, `opcode`/`funct` 0, `pc_plus4` `RESET_PC`+4.
- State transitions:
  - IDLE → REQ unconditionally on the next edge.
  - REQ: `imem_req` = 1 and `imem_addr` = `pc`. When `imem_ready` = 1 → WAIT.
  - WAIT: `imem_req` = 0. When `imem_rvalid` = 1, `instr` is loaded from `imem_rdata` → HOLD.
  - HOLD: `instr_valid` = 1. When `instr_ack` = 1:
    - `pc` is loaded with `next_pc`, `retired` increments and the state → REQ;
    - if `next_pc[1:0]` ≠ 0, the state → ERROR instead and `pc` is not updated.
  - ERROR: `fault` = 1, `imem_req` = 0, `instr_valid` = 0. The block stays in ERROR until reset.
- `next_pc` arithmetic (32-bit, modulo 2^32; `imm` = `instr[15:0]`):
  - sel 0: `pc_plus4`.
  - sel 1: `pc_plus4` + sign-extended `imm` shifted left by 2, i.e. `{{14{imm[15]}}, imm, 2'b00}`.
  - sel 2: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  - sel 3: `rs_data`.
- `imem_rvalid` is ignored in every state except WAIT, so stale responses after a reset are dropped.
- `instr_ack` is ignored outside HOLD.
- `imem_ready` is ignored outside REQ.
- A misaligned jump still counts as retired: `retired` increments on the faulting ack.

## Timing
- `imem_req`, `imem_addr` and `instr_valid` are decoded from registered state only, with no combinational path from inputs.
- `opcode` and `funct` are slices of the `instr` register.
- `next_pc` is combinational from `sel_pc`, `rs_data`, `instr` and `pc`. It is captured on the ack edge.
- A response is accepted no earlier than the cycle after the request is accepted.
- Minimum per instruction is 3 cycles:
  - REQ accepted in cycle N;
  - `imem_rvalid` in N+1;
  - HOLD with ack in N+2;
  - REQ for the next PC in N+3.
- Stall rules:
  - `imem_req` and `imem_addr` remain stable while `imem_ready` is low.
  - All HOLD outputs remain stable while `instr_ack` is low.
- After reset deasserts, the first `imem_req` rises after 1 edge (IDLE) and is visible in the following cycle.
- A reset asserted in any state takes effect immediately; any outstanding request is abandoned.

## Test plan
- Reset with `RESET_PC` = 0. Memory accepts immediately and returns 32'h8C08_0004 one cycle later → `imem_addr` = 0, then `instr_valid` = 1 with `opcode` = 6'h23. Ack with `sel_pc` = 0 → next `imem_addr` = 4, `retired` = 1.
- Branch: held `pc` = 32'h10, instruction 32'h1000_FFFF, ack with `sel_pc` = 1 → next `imem_addr` = 32'h10 (32'h14 − 4).
- Jump: held `pc` = 32'h4000_0020, instruction 32'h0800_0100, ack with `sel_pc` = 2 → next `imem_addr` = 32'h4000_0400.
- JR:
  - `sel_pc` = 3 with `rs_data` = 32'h102 → `fault` = 1, `imem_req` stays 0 thereafter, `pc` unchanged.
  - After reset, `rs_data` = 32'h100 → next `imem_addr` = 32'h100, `fault` = 0.
- Backpressure: hold `imem_ready` = 0 for 3 cycles, delay `imem_rvalid` by 4 cycles and hold `instr_ack` = 0 for 5 cycles → address, request and `instr` stay constant throughout, and there is exactly one `retired` increment.
- Reset during WAIT, followed by a stale `imem_rvalid` while in REQ → the response is ignored, `instr_valid` stays 0, and the request is reissued at `RESET_PC`.
